// File: rtl/fifo_vc_buffer.sv
// fifo_vc_buffer: NUM_VC circular FIFOs sharing one storage array, with per-VC counts, flags and error pulses.
// Define FIFO_VC_FWFT_EN for first-word fall-through reads; the default build uses a registered dout.
module fifo_vc_buffer #(
  parameter int WIDTH     = 16,
  parameter int ADDWIDTH  = 5,
  parameter int NUM_VC    = 4,
  parameter int VCW       = 2,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [VCW-1:0]                   wr_vc,
  input  logic [WIDTH-1:0]                 din,
  input  logic                             rd_en,
  input  logic [VCW-1:0]                   rd_vc,
  output logic [WIDTH-1:0]                 dout,
  output logic [NUM_VC-1:0]                full,
  output logic [NUM_VC-1:0]                empty,
  output logic [NUM_VC-1:0]                almost_full,
  output logic [NUM_VC-1:0]                almost_empty,
  output logic [NUM_VC*(ADDWIDTH+1)-1:0]   count,
  output logic                             err_ovf,
  output logic                             err_udf
);
  localparam int DEPTH = 2 ** ADDWIDTH;
  localparam int CW = ADDWIDTH + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_C = CW'(AE_MARGIN);
  logic [ADDWIDTH-1:0] head_q [NUM_VC];
  logic [ADDWIDTH-1:0] head_d [NUM_VC];
  logic [ADDWIDTH-1:0] tail_q [NUM_VC];
  logic [ADDWIDTH-1:0] tail_d [NUM_VC];
  logic [CW-1:0]       cnt_q  [NUM_VC];
  logic [CW-1:0]       cnt_d  [NUM_VC];
  logic [WIDTH-1:0]    mem_q  [NUM_VC*DEPTH];
  logic [NUM_VC-1:0]   wr_acc, rd_acc;
  logic [ADDWIDTH-1:0] wr_ptr, rd_ptr;
  logic                rd_avail;
  logic                err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
  logic [VCW+ADDWIDTH-1:0] wr_addr, rd_addr;
  always_comb begin
    full = '0;
    empty = '0;
    almost_full = '0;
    almost_empty = '0;
    count = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      full[v] = cnt_q[v] == FULL_C;
      empty[v] = cnt_q[v] == '0;
      almost_full[v] = cnt_q[v] >= AF_C;
      almost_empty[v] = cnt_q[v] <= AE_C;
      count[v*CW +: CW] = cnt_q[v];
    end
  end
  // A full VC still takes a write when the same VC is popped on that edge.
  always_comb begin
    wr_acc = '0;
    rd_acc = '0;
    wr_ptr = '0;
    rd_ptr = '0;
    rd_avail = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      rd_acc[v] = rd_en && rd_vc == VCW'(v) && !empty[v];
      wr_acc[v] = wr_en && wr_vc == VCW'(v) && (!full[v] || rd_acc[v]);
      if (wr_vc == VCW'(v)) wr_ptr = tail_q[v];
      if (rd_vc == VCW'(v)) begin
        rd_ptr = head_q[v];
        rd_avail = !empty[v];
      end
    end
  end
  assign wr_addr = {wr_vc, wr_ptr};
  assign rd_addr = {rd_vc, rd_ptr};
  always_comb begin
    err_ovf_d = wr_en && !(|wr_acc);
    err_udf_d = rd_en && !(|rd_acc);
    for (int v = 0; v < NUM_VC; v++) begin
      head_d[v] = rd_acc[v] ? head_q[v] + ADDWIDTH'(1) : head_q[v];
      tail_d[v] = wr_acc[v] ? tail_q[v] + ADDWIDTH'(1) : tail_q[v];
      cnt_d[v] = (wr_acc[v] && !rd_acc[v]) ? cnt_q[v] + CW'(1) :
                 (rd_acc[v] && !wr_acc[v]) ? cnt_q[v] - CW'(1) : cnt_q[v];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        head_q[v] <= '0;
        tail_q[v] <= '0;
        cnt_q[v] <= '0;
      end
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (|wr_acc) mem_q[wr_addr] <= din;
  end
  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`ifdef FIFO_VC_FWFT_EN
  assign dout = rd_avail ? mem_q[rd_addr] : '0;
`else
  logic [WIDTH-1:0] dout_q, dout_d;
  always_comb dout_d = (rd_en && rd_avail) ? mem_q[rd_addr] : dout_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dout_q <= '0;
    else dout_q <= dout_d;
  end
  assign dout = dout_q;
`endif
endmodule

// File: tb/tb_fifo_vc_buffer.sv
// tb_fifo_vc_buffer: directed checks of fill, overflow, same-edge read/write, underflow, interleave and mid-stream reset.
module tb_fifo_vc_buffer;
`ifdef FIFO_VC_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [1:0] wr_vc = '0, rd_vc = '0;
  logic [15:0] din = '0, dout, obs;
  logic [3:0] full, empty, almost_full, almost_empty;
  logic [23:0] count;
  logic err_ovf, err_udf;
  int checks = 0, errors = 0;

  fifo_vc_buffer dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_vc(wr_vc), .din(din),
    .rd_en(rd_en), .rd_vc(rd_vc), .dout(dout), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] cnt_of(input int v);
    return count[v*6 +: 6];
  endfunction

  // One clock of stimulus; obs is the word presented by the read (before the edge in FWFT, after it otherwise).
  task automatic cyc(input logic we, input logic [1:0] wv, input logic [15:0] d,
                     input logic re, input logic [1:0] rv, output logic [15:0] o);
    wr_en = we; wr_vc = wv; din = d; rd_en = re; rd_vc = rv;
    #1;
    o = dout;
    @(posedge clk);
    #1;
    if (!FWFT) o = dout;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (empty !== 4'hF) begin errors++; $display("FAIL reset_empty: got %h expected %h", empty, 4'hF); end
    checks++; if (full !== 4'h0) begin errors++; $display("FAIL reset_full: got %h expected %h", full, 4'h0); end
    checks++; if (almost_full !== 4'h0) begin errors++; $display("FAIL reset_af: got %h expected %h", almost_full, 4'h0); end
    checks++; if (almost_empty !== 4'hF) begin errors++; $display("FAIL reset_ae: got %h expected %h", almost_empty, 4'hF); end
    checks++; if (count !== 24'h0) begin errors++; $display("FAIL reset_count: got %h expected %h", count, 24'h0); end
    checks++; if ({err_ovf, err_udf} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected %b", {err_ovf, err_udf}, 2'b00); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_dout: got %h expected %h", dout, 16'h0); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 32; k++) begin
      cyc(1'b1, 2'd1, 16'(k), 1'b0, 2'd0, obs);
      checks++; if (almost_full[1] !== (k >= 31)) begin errors++; $display("FAIL fill_af k=%0d: got %b expected %b", k, almost_full[1], k >= 31); end
      checks++; if (almost_empty[1] !== (k <= 1)) begin errors++; $display("FAIL fill_ae k=%0d: got %b expected %b", k, almost_empty[1], k <= 1); end
    end
    checks++; if (full !== 4'b0010) begin errors++; $display("FAIL fill_full: got %b expected %b", full, 4'b0010); end
    checks++; if (cnt_of(1) !== 6'd32) begin errors++; $display("FAIL fill_count: got %0d expected %0d", cnt_of(1), 32); end
    checks++; if (empty !== 4'b1101) begin errors++; $display("FAIL fill_empty: got %b expected %b", empty, 4'b1101); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL fill_ovf: got %b expected %b", err_ovf, 1'b0); end
  endtask

  task automatic test_overflow();
    cyc(1'b1, 2'd1, 16'h0033, 1'b0, 2'd0, obs);
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected %b", err_ovf, 1'b1); end
    checks++; if (cnt_of(1) !== 6'd32) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", cnt_of(1), 32); end
    @(posedge clk);
    #1;
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected %b", err_ovf, 1'b0); end
  endtask

  task automatic test_full_rw();
    cyc(1'b1, 2'd1, 16'hBEEF, 1'b1, 2'd1, obs);
    checks++; if (obs !== 16'h0001) begin errors++; $display("FAIL rw_head: got %h expected %h", obs, 16'h0001); end
    checks++; if (cnt_of(1) !== 6'd32) begin errors++; $display("FAIL rw_count: got %0d expected %0d", cnt_of(1), 32); end
    checks++; if ({err_ovf, err_udf} !== 2'b00) begin errors++; $display("FAIL rw_err: got %b expected %b", {err_ovf, err_udf}, 2'b00); end
    for (int k = 2; k <= 33; k++) begin
      cyc(1'b0, 2'd0, 16'h0, 1'b1, 2'd1, obs);
      checks++;
      if (obs !== ((k == 33) ? 16'hBEEF : 16'(k))) begin
        errors++; $display("FAIL rw_drain k=%0d: got %h expected %h", k, obs, (k == 33) ? 16'hBEEF : 16'(k));
      end
    end
    checks++; if (empty !== 4'hF) begin errors++; $display("FAIL rw_empty: got %b expected %b", empty, 4'hF); end
  endtask

  task automatic test_underflow();
    cyc(1'b1, 2'd2, 16'h1234, 1'b1, 2'd2, obs);
    checks++; if (err_udf !== 1'b1) begin errors++; $display("FAIL udf_pulse: got %b expected %b", err_udf, 1'b1); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL udf_ovf: got %b expected %b", err_ovf, 1'b0); end
    checks++; if (cnt_of(2) !== 6'd1) begin errors++; $display("FAIL udf_count: got %0d expected %0d", cnt_of(2), 1); end
    checks++; if (obs !== (FWFT ? 16'h0 : 16'hBEEF)) begin errors++; $display("FAIL udf_dout: got %h expected %h", obs, FWFT ? 16'h0 : 16'hBEEF); end
    cyc(1'b0, 2'd0, 16'h0, 1'b1, 2'd2, obs);
    checks++; if (obs !== 16'h1234) begin errors++; $display("FAIL udf_read: got %h expected %h", obs, 16'h1234); end
    checks++; if (err_udf !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b expected %b", err_udf, 1'b0); end
    checks++; if (cnt_of(2) !== 6'd0) begin errors++; $display("FAIL udf_count0: got %0d expected %0d", cnt_of(2), 0); end
  endtask

  task automatic test_interleave();
    logic [15:0] q0[$], q3[$];
    logic [15:0] d, exp;
    logic [1:0] vc;
    logic we, re;
    for (int i = 0; i < 202; i++) begin
      vc = i[0] ? 2'd3 : 2'd0;
      we = i < 200;
      re = i >= 2;
      d = {i[0] ? 8'hC3 : 8'hC0, 8'(i)};
      exp = 16'h0;
      if (re) exp = (vc == 2'd3) ? q3.pop_front() : q0.pop_front();
      if (we) begin
        if (vc == 2'd3) q3.push_back(d);
        else q0.push_back(d);
      end
      cyc(we, vc, d, re, vc, obs);
      if (re) begin
        checks++; if (obs !== exp) begin errors++; $display("FAIL il_data i=%0d: got %h expected %h", i, obs, exp); end
      end
      checks++; if ({err_ovf, err_udf} !== 2'b00) begin errors++; $display("FAIL il_err i=%0d: got %b expected %b", i, {err_ovf, err_udf}, 2'b00); end
    end
    checks++; if (cnt_of(0) !== 6'd0 || cnt_of(3) !== 6'd0) begin errors++; $display("FAIL il_counts: got %0d/%0d expected 0/0", cnt_of(0), cnt_of(3)); end
    checks++; if (empty !== 4'hF) begin errors++; $display("FAIL il_empty: got %b expected %b", empty, 4'hF); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) cyc(1'b1, 2'd0, 16'h5000 + 16'(k), 1'b0, 2'd0, obs);
    checks++; if (cnt_of(0) !== 6'd5) begin errors++; $display("FAIL rm_pre: got %0d expected %0d", cnt_of(0), 5); end
    wr_en = 1'b1; wr_vc = 2'd0; din = 16'h7777;
    #2 reset = 1'b1;
    #1;
    checks++; if (empty !== 4'hF) begin errors++; $display("FAIL rm_empty: got %b expected %b", empty, 4'hF); end
    checks++; if (count !== 24'h0) begin errors++; $display("FAIL rm_count: got %h expected %h", count, 24'h0); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL rm_dout: got %h expected %h", dout, 16'h0); end
    wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 2'd0, 16'hA5A5, 1'b0, 2'd0, obs);
    checks++; if (cnt_of(0) !== 6'd1) begin errors++; $display("FAIL rm_wcount: got %0d expected %0d", cnt_of(0), 1); end
    cyc(1'b0, 2'd0, 16'h0, 1'b1, 2'd0, obs);
    checks++; if (obs !== 16'hA5A5) begin errors++; $display("FAIL rm_read: got %h expected %h", obs, 16'hA5A5); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_interleave();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
